// File: rtl/red_pitaya_asg_sweep_pkg.sv
// Shared types and constants for the ASG phase-step sweep generator.
//   - swp_state_e : sweep FSM states
//   - SWP_*       : sweep mode encodings for set_mode_i
//   - SWP_RSZ / SWP_STEP_W : default buffer address width and matching step width
package red_pitaya_asg_sweep_pkg;

  localparam int SWP_RSZ    = 14;
  localparam int SWP_STEP_W = SWP_RSZ + 16;

  localparam logic [1:0] SWP_ONCE = 2'd0;
  localparam logic [1:0] SWP_SAW  = 2'd1;
  localparam logic [1:0] SWP_TRI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } swp_state_e;

endpackage

// File: rtl/red_pitaya_asg_sweep_tick.sv
// Update-interval timer for the sweep generator: a 32-bit reloadable
// down-counter. tick_o is high for the cycle in which the counter sits at
// zero while running; on that edge the counter reloads reload_val_i.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : force counter to zero (highest priority after reset)
//   load_i         : load load_val_i (start of a sweep)
//   run_i          : count down / reload while high, hold otherwise
//   load_val_i     : value taken on load_i
//   reload_val_i   : value taken when the counter expires
//   tick_o         : update strobe
module red_pitaya_asg_sweep_tick (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic        run_i,
  input  logic [31:0] load_val_i,
  input  logic [31:0] reload_val_i,
  output logic        tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tick_o = run_i && (cnt_q == 32'd0);

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 32'd0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i) begin
      cnt_d = (cnt_q == 32'd0) ? reload_val_i : cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst_i) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/red_pitaya_asg_sweep.sv
// Phase-step sweep generator feeding one ASG channel's step input.
// Moves step_o linearly from start to stop at a programmable update rate,
// in one-shot, sawtooth or triangle mode. All logic in the DAC clock domain.
//   dac_clk_i, dac_rst_i : clock, synchronous active-high reset
//   set_en_i             : sweep enable; low forces IDLE (step_o tracks start)
//   set_start_i/stop_i   : sweep end points (unsigned, 16 fractional bits)
//   set_inc_i            : increment magnitude per update
//   set_div_i            : update interval minus one, in clocks
//   set_mode_i           : 0/3 one-shot, 1 sawtooth, 2 triangle
//   trig_i               : start / restart pulse
//   step_o               : registered step value to the channel
//   upd_o, wrap_o        : pulses aligned with the step_o change they describe
//   busy_o               : high while sweeping
module red_pitaya_asg_sweep
  import red_pitaya_asg_sweep_pkg::*;
#(
  parameter int RSZ = SWP_RSZ
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              set_en_i,
  input  logic [RSZ+15:0]   set_start_i,
  input  logic [RSZ+15:0]   set_stop_i,
  input  logic [RSZ+15:0]   set_inc_i,
  input  logic [31:0]       set_div_i,
  input  logic [1:0]        set_mode_i,
  input  logic              trig_i,
  output logic [RSZ+15:0]   step_o,
  output logic              upd_o,
  output logic              wrap_o,
  output logic              busy_o
);

  localparam int SW = RSZ + 16;

  swp_state_e     state_q;
  logic [SW-1:0]  step_q;
  logic           upd_q;
  logic           wrap_q;
  logic           busy_q;
  logic           dir_q;      // 1 = counting up
  logic           ret_q;      // triangle return leg: target is start
  logic           rld_q;      // sawtooth: next update reloads start

  // Shadow copies taken at trigger; RUN ignores live set_* changes.
  logic [SW-1:0]  start_q;
  logic [SW-1:0]  stop_q;
  logic [SW-1:0]  inc_q;
  logic [31:0]    div_q;
  logic [1:0]     mode_q;

  logic           tick;
  logic [SW-1:0]  tgt_d;
  logic [SW:0]    sum_d;
  logic [SW-1:0]  nxt_d;
  logic           end_d;

  red_pitaya_asg_sweep_tick u_tick (
    .clk_i        (dac_clk_i),
    .rst_i        (dac_rst_i),
    .clr_i        (~set_en_i),
    .load_i       (set_en_i & trig_i),
    .run_i        (state_q == ST_RUN),
    .load_val_i   (set_div_i),
    .reload_val_i (div_q),
    .tick_o       (tick)
  );

  // Next-step arithmetic one bit wider than the step so the up sum cannot
  // overflow and a down result below zero shows up as the borrow bit.
  // Reaching the target exactly ends the leg in either direction, so a
  // triangle return leg landing on start wraps on that same update.
  always_comb begin
    tgt_d = ret_q ? start_q : stop_q;
    if (dir_q) begin
      sum_d = {1'b0, step_q} + {1'b0, inc_q};
      end_d = (sum_d >= {1'b0, tgt_d});
    end else begin
      sum_d = {1'b0, step_q} - {1'b0, inc_q};
      end_d = sum_d[SW] || (sum_d <= {1'b0, tgt_d});
    end
    nxt_d = end_d ? tgt_d : sum_d[SW-1:0];
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b1;
      ret_q   <= 1'b0;
      rld_q   <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      div_q   <= '0;
      mode_q  <= SWP_ONCE;
    end else begin
      upd_q  <= 1'b0;
      wrap_q <= 1'b0;
      if (!set_en_i) begin
        state_q <= ST_IDLE;
        step_q  <= set_start_i;
        busy_q  <= 1'b0;
      end else if (trig_i) begin
        // Same action from IDLE, RUN (restart) and HOLD.
        start_q <= set_start_i;
        stop_q  <= set_stop_i;
        inc_q   <= set_inc_i;
        div_q   <= set_div_i;
        mode_q  <= set_mode_i;
        step_q  <= set_start_i;
        dir_q   <= (set_stop_i >= set_start_i);
        ret_q   <= 1'b0;
        rld_q   <= 1'b0;
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: step_q <= set_start_i;
          ST_RUN: begin
            if (tick) begin
              upd_q <= 1'b1;
              if (rld_q) begin
                step_q <= start_q;
                rld_q  <= 1'b0;
              end else begin
                step_q <= nxt_d;
                if (end_d) begin
                  case (mode_q)
                    SWP_SAW: begin
                      wrap_q <= 1'b1;
                      rld_q  <= 1'b1;
                    end
                    SWP_TRI: begin
                      // Forward leg flips toward start; return leg flips back and wraps.
                      dir_q  <= ~dir_q;
                      ret_q  <= ~ret_q;
                      wrap_q <= ret_q;
                    end
                    default: begin
                      wrap_q  <= 1'b1;
                      state_q <= ST_HOLD;
                      busy_q  <= 1'b0;
                    end
                  endcase
                end
              end
            end
          end
          default: ; // HOLD: step_o frozen until re-trigger or disable
        endcase
      end
    end
  end

  assign step_o = step_q;
  assign upd_o  = upd_q;
  assign wrap_o = wrap_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Directed-vector bench for red_pitaya_asg_sweep with hand-computed expectations.
module tb_red_pitaya_asg_sweep;
  import red_pitaya_asg_sweep_pkg::*;

  localparam int SW = SWP_STEP_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [SW-1:0] start, stop, inc;
  logic [31:0]   div;
  logic [1:0]    mode;
  logic          trig;
  logic [SW-1:0] step;
  logic          upd, wrap, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  red_pitaya_asg_sweep #(.RSZ(SWP_RSZ)) dut (
    .dac_clk_i   (clk),
    .dac_rst_i   (rst),
    .set_en_i    (en),
    .set_start_i (start),
    .set_stop_i  (stop),
    .set_inc_i   (inc),
    .set_div_i   (div),
    .set_mode_i  (mode),
    .trig_i      (trig),
    .step_o      (step),
    .upd_o       (upd),
    .wrap_o      (wrap),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [SW-1:0] s, input logic [SW-1:0] e, input logic [SW-1:0] i,
                     input logic [31:0] d, input logic [1:0] m, input string tag);
    start = s; stop = e; inc = i; div = d; mode = m;
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    check({tag, " start step"}, 32'(step), 32'(s));
    check({tag, " start busy"}, 32'(busy), 32'd1);
    check({tag, " start upd"},  32'(upd),  32'd0);
  endtask

  // Wait out one update interval of d+1 clocks and check the update it produces.
  task automatic upd_chk(input string tag, input int d, input logic [SW-1:0] exp_step, input logic exp_wrap);
    repeat (d) cyc();
    if (d > 0) check({tag, " pre upd"}, 32'(upd), 32'd0);
    cyc();
    check({tag, " step"}, 32'(step), 32'(exp_step));
    check({tag, " upd"},  32'(upd),  32'd1);
    check({tag, " wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; trig = 1'b0;
    start = '0; stop = '0; inc = '0; div = '0; mode = SWP_ONCE;
    cyc(); cyc();
    check("reset step", 32'(step), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset upd",  32'(upd),  32'd0);
    check("reset wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    cyc();

    // Up, one-shot, update every 4 clocks.
    arm(30'h10000, 30'h50000, 30'h10000, 32'd3, SWP_ONCE, "once");
    upd_chk("once u1", 3, 30'h20000, 1'b0);
    upd_chk("once u2", 3, 30'h30000, 1'b0);
    upd_chk("once u3", 3, 30'h40000, 1'b0);
    upd_chk("once u4", 3, 30'h50000, 1'b1);
    cyc();
    check("once hold busy", 32'(busy), 32'd0);
    check("once hold wrap", 32'(wrap), 32'd0);
    start = 30'h777;
    repeat (5) cyc();
    check("once hold step", 32'(step), 32'h50000);
    check("once hold upd",  32'(upd),  32'd0);

    // Down with clamp at stop, update every clock (restart from HOLD).
    arm(30'h50000, 30'h18000, 30'h10000, 32'd0, SWP_ONCE, "clamp");
    upd_chk("clamp u1", 0, 30'h40000, 1'b0);
    upd_chk("clamp u2", 0, 30'h30000, 1'b0);
    upd_chk("clamp u3", 0, 30'h20000, 1'b0);
    upd_chk("clamp u4", 0, 30'h18000, 1'b1);
    cyc();
    check("clamp hold busy", 32'(busy), 32'd0);

    // Sawtooth, update every 2 clocks, two full periods.
    arm(30'h0, 30'h30000, 30'h10000, 32'd1, SWP_SAW, "saw");
    upd_chk("saw u1", 1, 30'h10000, 1'b0);
    upd_chk("saw u2", 1, 30'h20000, 1'b0);
    upd_chk("saw u3", 1, 30'h30000, 1'b1);
    upd_chk("saw u4", 1, 30'h00000, 1'b0);
    upd_chk("saw u5", 1, 30'h10000, 1'b0);
    upd_chk("saw u6", 1, 30'h20000, 1'b0);
    upd_chk("saw u7", 1, 30'h30000, 1'b1);
    upd_chk("saw u8", 1, 30'h00000, 1'b0);
    check("saw busy", 32'(busy), 32'd1);

    // Triangle, update every clock.
    arm(30'h10000, 30'h30000, 30'h10000, 32'd0, SWP_TRI, "tri");
    upd_chk("tri u1", 0, 30'h20000, 1'b0);
    upd_chk("tri u2", 0, 30'h30000, 1'b0);
    upd_chk("tri u3", 0, 30'h20000, 1'b0);
    upd_chk("tri u4", 0, 30'h10000, 1'b1);
    upd_chk("tri u5", 0, 30'h20000, 1'b0);
    upd_chk("tri u6", 0, 30'h30000, 1'b0);

    // Restart mid-sweep: back to start, no wrap, sweep resumes forward.
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    check("restart step", 32'(step), 32'h10000);
    check("restart wrap", 32'(wrap), 32'd0);
    check("restart upd",  32'(upd),  32'd0);
    check("restart busy", 32'(busy), 32'd1);
    upd_chk("restart u1", 0, 30'h20000, 1'b0);

    // Disable: IDLE next edge, step follows live start.
    en = 1'b0;
    start = 30'h12340;
    cyc();
    check("dis busy", 32'(busy), 32'd0);
    check("dis step", 32'(step), 32'h12340);
    check("dis upd",  32'(upd),  32'd0);
    start = 30'h0abcd;
    cyc();
    check("dis step live", 32'(step), 32'h0abcd);
    en = 1'b1;
    cyc();

    // inc = 0, start != stop: step stuck at start, updates keep coming.
    arm(30'h10000, 30'h30000, 30'h0, 32'd0, SWP_ONCE, "inc0");
    upd_chk("inc0 u1", 0, 30'h10000, 1'b0);
    upd_chk("inc0 u2", 0, 30'h10000, 1'b0);
    upd_chk("inc0 u3", 0, 30'h10000, 1'b0);
    check("inc0 busy", 32'(busy), 32'd1);

    // start == stop, triangle: wrap on every second update.
    arm(30'h20000, 30'h20000, 30'h10000, 32'd0, SWP_TRI, "eq");
    upd_chk("eq u1", 0, 30'h20000, 1'b0);
    upd_chk("eq u2", 0, 30'h20000, 1'b1);
    upd_chk("eq u3", 0, 30'h20000, 1'b0);
    upd_chk("eq u4", 0, 30'h20000, 1'b1);

    // Reset mid-RUN: outputs clear, no pulses until the next trigger.
    arm(30'h10000, 30'h50000, 30'h10000, 32'd0, SWP_ONCE, "rst");
    upd_chk("rst u1", 0, 30'h20000, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst step", 32'(step), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst upd",  32'(upd),  32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rst quiet upd",  32'(upd),  32'd0);
      check("rst quiet wrap", 32'(wrap), 32'd0);
      check("rst quiet busy", 32'(busy), 32'd0);
    end
    arm(30'h10000, 30'h50000, 30'h10000, 32'd0, SWP_ONCE, "rst re");
    upd_chk("rst re u1", 0, 30'h20000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
